// File: rtl/wb_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter_if
// Bundle of every bus-level signal around the register-file write arbiter.
//   ALU side   : alu_valid, alu_rd, alu_data -> alu_ready
//   Load side  : ld_valid, ld_rd, ld_data    -> ld_ready
//   Write port : rd, write_data, RegWrite
//   Status     : pending_mask (per-register buffered-load flag), fifo_count
// Modports:
//   slave  - the arbiter itself (consumes results, drives the write port)
//   master - the environment (produces results, observes the write port)
// DATA_W / FIFO_DEPTH must match the parameters of the attached arbiter.
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;

   logic              ld_valid;
   logic [4:0]        ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;

   logic [4:0]        rd;
   logic [DATA_W-1:0] write_data;
   logic              RegWrite;

   logic [31:0]       pending_mask;
   logic [CNT_W-1:0]  fifo_count;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output alu_ready, ld_ready,
      output rd, write_data, RegWrite,
      output pending_mask, fifo_count
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  alu_ready, ld_ready,
      input  rd, write_data, RegWrite,
      input  pending_mask, fifo_count
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
// Drives the single integer register-file write port from two sources:
// single-cycle ALU results (priority) and out-of-band load responses held
// in a small FIFO. A starvation counter forces a load pop after STARVE_MAX
// consecutive lost arbitrations. The write port is registered (1-cycle
// latency from acceptance/pop). pending_mask flags registers that a live
// buffered load will still write, for decode hazard detection.
// Ports:
//   clk   - clock, all state on rising edge
//   RSTn  - asynchronous active-low reset
//   en    - global enable, low freezes all state
//   wb    - wb_write_arbiter_if.slave (ALU/load handshakes, write port,
//           pending_mask, fifo_count)
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2,   // power of two, >= 2
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              RSTn,
   input  logic              en,
   wb_write_arbiter_if.slave wb
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   // Load-response buffer. A "live" entry will still produce a register
   // write; a killed entry stays in place and pops as a silent write.
   logic [4:0]            r_fifo_rd   [FIFO_DEPTH];
   logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_live;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [STV_W-1:0]      r_starve;

   logic [4:0]            r_rd;
   logic [DATA_W-1:0]     r_write_data;
   logic                  r_reg_write;

   logic                  w_fifo_empty;
   logic                  w_force_ld;
   logic                  w_alu_ready;
   logic                  w_ld_ready;
   logic                  w_alu_xfer;
   logic                  w_ld_xfer;
   logic                  w_enq;
   logic                  w_pop;
   logic [31:0]           w_pending;

   assign w_fifo_empty = (r_count == '0);
   assign w_force_ld   = !w_fifo_empty && (r_starve >= STV_W'(STARVE_MAX));
   assign w_alu_ready  = en && !w_force_ld;
   // Based on current occupancy only: a full FIFO refuses even while popping.
   assign w_ld_ready   = en && (r_count < CNT_W'(FIFO_DEPTH));
   assign w_alu_xfer   = wb.alu_valid && w_alu_ready;
   assign w_ld_xfer    = wb.ld_valid && w_ld_ready;
   // Loads to x0 are consumed but never buffered.
   assign w_enq        = w_ld_xfer && (wb.ld_rd != 5'd0);
   assign w_pop        = en && !w_alu_xfer && !w_fifo_empty;

   // Pending mask is a pure function of the live bits, so an asynchronous
   // reset of those bits clears it immediately.
   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      w_pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (r_fifo_live[PTR_W'(i)])
            w_pending[r_fifo_rd[PTR_W'(i)]] = 1'b1;
      end
   end

   // NOTE: payload storage has no reset; r_fifo_live alone qualifies it, and
   // every popped entry was written before it was marked live.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_fifo_rd[r_wr_ptr]   <= wb.ld_rd;
         r_fifo_data[r_wr_ptr] <= wb.ld_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every read in
   // this block sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_fifo_live  <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_starve     <= '0;
         r_rd         <= '0;
         r_write_data <= '0;
         r_reg_write  <= 1'b0;
      end else if (en) begin
         // WAW: an accepted ALU write supersedes every older buffered load to
         // the same register. The load being enqueued this cycle is younger
         // and lands in an empty slot, so it is untouched by this loop.
         if (w_alu_xfer) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               if (r_fifo_live[PTR_W'(i)] && (r_fifo_rd[PTR_W'(i)] == wb.alu_rd))
                  r_fifo_live[PTR_W'(i)] <= 1'b0;
            end
         end

         if (w_pop) begin
            r_fifo_live[r_rd_ptr] <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + 1'b1;
         end

         if (w_enq) begin
            r_fifo_live[r_wr_ptr] <= 1'b1;
            r_wr_ptr              <= r_wr_ptr + 1'b1;
         end

         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         // Counts consecutive lost arbitrations of a present FIFO head.
         if (w_fifo_empty || w_pop)
            r_starve <= '0;
         else if (w_alu_xfer && (r_starve != STV_W'(STARVE_MAX)))
            r_starve <= r_starve + 1'b1;

         // Registered write port; x0 and killed entries update the address
         // and data but never raise the strobe.
         if (w_alu_xfer) begin
            r_rd         <= wb.alu_rd;
            r_write_data <= wb.alu_data;
            r_reg_write  <= (wb.alu_rd != 5'd0);
         end else if (w_pop) begin
            r_rd         <= r_fifo_rd[r_rd_ptr];
            r_write_data <= r_fifo_data[r_rd_ptr];
            r_reg_write  <= r_fifo_live[r_rd_ptr];
         end else begin
            r_reg_write  <= 1'b0;
         end
      end else begin
         // Frozen: address/data hold, but no write is issued.
         r_reg_write <= 1'b0;
      end
   end

   assign wb.alu_ready    = w_alu_ready;
   assign wb.ld_ready     = w_ld_ready;
   assign wb.rd           = r_rd;
   assign wb.write_data   = r_write_data;
   assign wb.RegWrite     = r_reg_write;
   assign wb.pending_mask = w_pending;
   assign wb.fifo_count   = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter
// Table of per-cycle vectors (inputs plus hand-derived expected handshakes,
// occupancy, pending mask and the resulting registered write), followed by
// hand-written reset sequences. Expected writes go through a scoreboard
// queue: pushed when a vector is driven, popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;
   logic clk;
   logic RSTn;
   logic en;

   wb_write_arbiter_if #(.DATA_W(32), .FIFO_DEPTH(2)) bus ();

   wb_write_arbiter #(.DATA_W(32), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk  (clk),
      .RSTn (RSTn),
      .en   (en),
      .wb   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic        ar;
      logic        lr;
      logic [1:0]  cnt;
      logic [31:0] mask;
      logic        wr;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic        chk;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        chk;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t row(input logic e, input logic av, input logic [4:0] ard,
                                input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldat, input logic ar, input logic lr,
                                input logic [1:0] cnt, input logic [31:0] mask, input logic wr,
                                input logic [4:0] wrd, input logic [31:0] wdat, input logic chk);
      vec_t v;
      v.en = e; v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
      v.ar = ar; v.lr = lr; v.cnt = cnt; v.mask = mask;
      v.wr = wr; v.wrd = wrd; v.wdat = wdat; v.chk = chk;
      return v;
   endfunction

   // Drive one cycle: check pre-edge status, queue the expected write,
   // then compare the registered write port just after the edge.
   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      en            = v.en;
      bus.alu_valid = v.av;
      bus.alu_rd    = v.ard;
      bus.alu_data  = v.adat;
      bus.ld_valid  = v.lv;
      bus.ld_rd     = v.lrd;
      bus.ld_data   = v.ldat;
      #1;
      check($sformatf("v%0d alu_ready", n_vec), 32'(bus.alu_ready), 32'(v.ar));
      check($sformatf("v%0d ld_ready", n_vec), 32'(bus.ld_ready), 32'(v.lr));
      check($sformatf("v%0d fifo_count", n_vec), 32'(bus.fifo_count), 32'(v.cnt));
      check($sformatf("v%0d pending_mask", n_vec), bus.pending_mask, v.mask);
      sb.push_back('{wr: v.wr, rd: v.wrd, data: v.wdat, chk: v.chk});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d RegWrite", n_vec), 32'(bus.RegWrite), 32'(e.wr));
      if (e.chk) begin
         check($sformatf("v%0d rd", n_vec), 32'(bus.rd), 32'(e.rd));
         check($sformatf("v%0d write_data", n_vec), bus.write_data, e.data);
      end
      n_vec++;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
   endtask

   initial begin
      //          en av ard adat       lv lrd ldat      ar lr cnt mask           wr wrd wdat      chk
      // ALU stream
      tbl.push_back(row(1, 1, 5,  'h11,   0, 0,  0,       1, 1, 0, 0,             1, 5,  'h11,    1));
      tbl.push_back(row(1, 1, 6,  'h22,   0, 0,  0,       1, 1, 0, 0,             1, 6,  'h22,    1));
      // Load buffering: accepted, visible in mask, written next cycle
      tbl.push_back(row(1, 0, 0,  0,      1, 9,  'hDEAD,  1, 1, 0, 0,             0, 6,  'h22,    1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 1, 'h200,         1, 9,  'hDEAD,  1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 0, 0,             0, 9,  'hDEAD,  1));
      // Starvation: load rd3 loses 4 times, then is forced through
      tbl.push_back(row(1, 1, 10, 'hA0,   1, 3,  'h33,    1, 1, 0, 0,             1, 10, 'hA0,    1));
      tbl.push_back(row(1, 1, 11, 'hA1,   0, 0,  0,       1, 1, 1, 'h8,           1, 11, 'hA1,    1));
      tbl.push_back(row(1, 1, 12, 'hA2,   0, 0,  0,       1, 1, 1, 'h8,           1, 12, 'hA2,    1));
      tbl.push_back(row(1, 1, 13, 'hA3,   0, 0,  0,       1, 1, 1, 'h8,           1, 13, 'hA3,    1));
      tbl.push_back(row(1, 1, 14, 'hA4,   0, 0,  0,       1, 1, 1, 'h8,           1, 14, 'hA4,    1));
      tbl.push_back(row(1, 1, 15, 'hA5,   0, 0,  0,       0, 1, 1, 'h8,           1, 3,  'h33,    1));
      tbl.push_back(row(1, 1, 15, 'hA5,   0, 0,  0,       1, 1, 0, 0,             1, 15, 'hA5,    1));
      // Full FIFO: third load held off until the first pop
      tbl.push_back(row(1, 1, 16, 'hB0,   1, 20, 'h200,   1, 1, 0, 0,             1, 16, 'hB0,    1));
      tbl.push_back(row(1, 1, 17, 'hB1,   1, 21, 'h201,   1, 1, 1, 'h0010_0000,   1, 17, 'hB1,    1));
      tbl.push_back(row(1, 1, 18, 'hB2,   1, 22, 'h202,   1, 0, 2, 'h0030_0000,   1, 18, 'hB2,    1));
      tbl.push_back(row(1, 0, 0,  0,      1, 22, 'h202,   1, 0, 2, 'h0030_0000,   1, 20, 'h200,   1));
      tbl.push_back(row(1, 0, 0,  0,      1, 22, 'h202,   1, 1, 1, 'h0020_0000,   1, 21, 'h201,   1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 1, 'h0040_0000,   1, 22, 'h202,   1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 0, 0,             0, 22, 'h202,   1));
      // WAW kill: older load to x7 superseded by ALU write
      tbl.push_back(row(1, 1, 8,  'h88,   1, 7,  'hAAAA,  1, 1, 0, 0,             1, 8,  'h88,    1));
      tbl.push_back(row(1, 1, 7,  'h5555, 0, 0,  0,       1, 1, 1, 'h80,          1, 7,  'h5555,  1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 1, 0,             0, 7,  'hAAAA,  1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 0, 0,             0, 7,  'hAAAA,  1));
      // Same-cycle ALU and load to x12: the load is younger and survives
      tbl.push_back(row(1, 1, 12, 'hC0,   1, 12, 'hC1,    1, 1, 0, 0,             1, 12, 'hC0,    1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 1, 'h1000,        1, 12, 'hC1,    1));
      // x0: ALU write silent, load to x0 not buffered
      tbl.push_back(row(1, 1, 0,  'h77,   0, 0,  0,       1, 1, 0, 0,             0, 0,  'h77,    1));
      tbl.push_back(row(1, 0, 0,  0,      1, 0,  'h99,    1, 1, 0, 0,             0, 0,  'h77,    1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 0, 0,             0, 0,  'h77,    1));
      // en=0 freezes everything, buffered load drains after re-enable
      tbl.push_back(row(1, 1, 25, 'hE0,   1, 26, 'hE1,    1, 1, 0, 0,             1, 25, 'hE0,    1));
      tbl.push_back(row(0, 1, 27, 'hE2,   1, 28, 'hE3,    0, 0, 1, 'h0400_0000,   0, 25, 'hE0,    1));
      tbl.push_back(row(0, 1, 27, 'hE2,   1, 28, 'hE3,    0, 0, 1, 'h0400_0000,   0, 25, 'hE0,    1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 1, 'h0400_0000,   1, 26, 'hE1,    1));
      tbl.push_back(row(1, 0, 0,  0,      0, 0,  0,       1, 1, 0, 0,             0, 26, 'hE1,    1));

      // Reset state
      RSTn = 1'b0;
      en   = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check("reset rd", 32'(bus.rd), 32'd0);
      check("reset write_data", bus.write_data, 32'd0);
      check("reset RegWrite", 32'(bus.RegWrite), 32'd0);
      check("reset fifo_count", 32'(bus.fifo_count), 32'd0);
      check("reset pending_mask", bus.pending_mask, 32'd0);
      @(negedge clk);
      RSTn = 1'b1;
      #1;
      check("post-reset ld_ready", 32'(bus.ld_ready), 32'd1);
      check("post-reset alu_ready", 32'(bus.alu_ready), 32'd1);
      n_vec++;

      foreach (tbl[i]) apply(tbl[i]);

      // Reset mid-operation with two loads buffered and a write in flight
      apply(row(1, 1, 30, 'hF0, 1, 1, 'h101, 1, 1, 0, 0,     1, 30, 'hF0, 1));
      apply(row(1, 1, 31, 'hF1, 1, 2, 'h102, 1, 1, 1, 'h2,   1, 31, 'hF1, 1));
      @(negedge clk);
      idle_inputs();
      #1;
      check("pre-reset fifo_count", 32'(bus.fifo_count), 32'd2);
      check("pre-reset pending_mask", bus.pending_mask, 32'h6);
      check("pre-reset RegWrite", 32'(bus.RegWrite), 32'd1);
      RSTn = 1'b0;
      #1;
      check("async reset fifo_count", 32'(bus.fifo_count), 32'd0);
      check("async reset pending_mask", bus.pending_mask, 32'd0);
      check("async reset RegWrite", 32'(bus.RegWrite), 32'd0);
      check("async reset rd", 32'(bus.rd), 32'd0);
      @(posedge clk);
      #1;
      check("reset held RegWrite", 32'(bus.RegWrite), 32'd0);
      @(negedge clk);
      RSTn = 1'b1;
      n_vec++;
      // Nothing buffered survived: an idle cycle produces no write
      apply(row(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side driver for the integer register file.
- Merges two result sources into the single register-file write port (rd, write_data, RegWrite):
  - single-cycle ALU results;
  - out-of-band load responses, held in a small FIFO.
- Registers the write port and tracks destinations of buffered loads in a pending mask for decode hazard detection.
- ALU results have priority; a starvation counter guarantees load forward progress.

Parameters:
- DATA_W, 32, width of result data and write_data.
- FIFO_DEPTH, 2, load-response buffer entries (power of two, ≥2).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO head may lose arbitration before loads take priority.

Ports:
- clk  in  1  clock, all state on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes all state.
- alu_valid  in  1  ALU result present.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- ld_valid  in  1  load response present.
- ld_rd  in  5  load destination register.
- ld_data  in  DATA_W  load data.
- ld_ready  out  1  FIFO can accept a load response.
- rd  out  5  register-file write address.
- write_data  out  DATA_W  register-file write data.
- RegWrite  out  1  register-file write strobe.
- pending_mask  out  32  bit i set while a live buffered load targets x_i.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (async, RSTn=0):
  - rd=0, write_data=0, RegWrite=0.
  - FIFO empty, starve counter=0, pending_mask=0.
  - ld_ready=1 after reset releases.
- Handshakes:
  - Transfer on valid&ready.
  - ld_ready = en & (fifo_count<FIFO_DEPTH). It is registered-state-derived and does not depend on ld_valid.
  - alu_ready = en & !force_ld.
- force_ld = FIFO non-empty & starve_cnt ≥ STARVE_MAX.
- Arbitration (one write per cycle, en=1):
  - If alu transfer: output = ALU result. If the FIFO head exists, starve_cnt++ (saturating).
  - Else if FIFO non-empty: pop head, output = head, starve_cnt=0.
  - Else: RegWrite=0.
  - starve_cnt clears whenever the FIFO is empty or the head pops.
- Latency: exactly 1 cycle from an accepted ALU transfer / FIFO pop to the RegWrite pulse.
  - A load accepted into an empty FIFO can pop the following cycle, so its earliest write is 2 cycles after acceptance.
- Register x0:
  - Transfers with rd=0 are accepted and consumed but produce RegWrite=0. rd/write_data still update.
  - Loads to x0 are not enqueued and do not set pending_mask.
- Ordering / WAW:
  - An accepted ALU write to register R kills every live FIFO entry with rd=R. A killed entry remains in the FIFO, pops normally with RegWrite=0, and clears its pending bit at kill time.
  - A load accepted in the same cycle as an ALU write to the same R is not killed, because the load is younger.
- pending_mask:
  - Bit set on enqueue.
  - Bit cleared on pop or kill, unless another live entry still targets R. Implement it as OR over the live entries.
- Simultaneous enqueue and pop when full: not allowed. ld_ready is based on the current count, so a full FIFO refuses input even while popping.
- en=0:
  - No transfers, RegWrite=0, all counters and the FIFO hold.
  - rd/write_data hold their previous values.
- Reset mid-operation: buffered loads are discarded, pending_mask clears immediately (asynchronous), and no write is issued.

Test Plan:
- Reset then ALU stream: alu_valid=1 with (rd=5, data=0x11) then (rd=6, data=0x22) → RegWrite pulses with rd=5/0x11 then rd=6/0x22, each one cycle after acceptance; alu_ready=1 throughout.
- Load buffering: load (rd=9, 0xDEAD) while ALU is idle → pending_mask[9]=1 for one cycle; next cycle rd=9, 0xDEAD, RegWrite=1; mask returns to 0.
- Starvation: continuous ALU valid plus one buffered load (rd=3), STARVE_MAX=4 → 4 ALU writes, then alu_ready=0 for one cycle and load rd=3 is written, then the ALU resumes.
- Full FIFO: 2 loads enqueued while the ALU is busy → fifo_count=2, ld_ready=0; a third ld_valid is held off until the first pop.
- WAW kill: load (rd=7, 0xAAAA) buffered, then ALU (rd=7, 0x5555) → register write rd=7/0x5555; the later pop of the load entry shows RegWrite=0; pending_mask[7] clears at the ALU acceptance.
- x0 and reset: ALU rd=0 → RegWrite stays 0. Assert RSTn=0 with 2 loads buffered → fifo_count=0, pending_mask=0, RegWrite=0 asynchronously.
